// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared types and constants for the pipeline controller.
//   REG_W             : register-number width used by the hazard comparators
//   SRAM_WAIT_MAX_DEF : default cycle budget for one SRAM access
//   sram_state_e      : SRAM access FSM states (IDLE / ACCESS / DONE)
//   reg_hit()         : source/destination match qualified by write-back enable
//   sat_inc()         : 32-bit saturating increment for the optional statistics
package pipe_ctrl_pkg;

    localparam int REG_W             = 4;
    localparam int SRAM_WAIT_MAX_DEF = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } sram_state_e;

    // A source depends on a producer only if the producer actually writes back.
    function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dest,
                                     input logic             wb_en);
        return wb_en & (src == dest);
    endfunction

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic        en);
        logic [31:0] res;
        if (en && (value != 32'hFFFF_FFFF)) begin
            res = value + 32'd1;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- bundle of all pipeline-side and SRAM-side signals of pipe_ctrl.
//   slave  : the controller (reads i_*, drives o_*)
//   master : the pipeline / environment (drives i_*, reads o_*)
//   Inputs : fwd_en, ID sources, EXE/MEM destinations and enables, SRAM
//            request/ready, branch_taken.
//   Outputs: sram_req, sram_freeze, freeze, flush, id_bubble, sram_err.
//   With PIPE_CTRL_STATS_EN defined, three 32-bit statistics outputs are added.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic             i_fwd_en;
    logic [REG_W-1:0] i_id_src1;
    logic [REG_W-1:0] i_id_src2;
    logic             i_id_two_src;
    logic [REG_W-1:0] i_exe_dest;
    logic [REG_W-1:0] i_mem_dest;
    logic             i_exe_wb_en;
    logic             i_mem_wb_en;
    logic             i_exe_mem_r_en;
    logic             i_mem_r_en;
    logic             i_mem_w_en;
    logic             i_sram_ready;
    logic             i_branch_taken;

    logic             o_sram_req;
    logic             o_sram_freeze;
    logic             o_freeze;
    logic             o_flush;
    logic             o_id_bubble;
    logic             o_sram_err;
`ifdef PIPE_CTRL_STATS_EN
    logic [31:0]      o_stall_cycles;
    logic [31:0]      o_flush_count;
    logic [31:0]      o_timeout_count;
`endif

    modport slave (
        input  i_fwd_en, i_id_src1, i_id_src2, i_id_two_src,
               i_exe_dest, i_mem_dest, i_exe_wb_en, i_mem_wb_en,
               i_exe_mem_r_en, i_mem_r_en, i_mem_w_en, i_sram_ready,
               i_branch_taken,
`ifdef PIPE_CTRL_STATS_EN
        output o_stall_cycles, o_flush_count, o_timeout_count,
`endif
        output o_sram_req, o_sram_freeze, o_freeze, o_flush, o_id_bubble,
               o_sram_err
    );

    modport master (
        output i_fwd_en, i_id_src1, i_id_src2, i_id_two_src,
               i_exe_dest, i_mem_dest, i_exe_wb_en, i_mem_wb_en,
               i_exe_mem_r_en, i_mem_r_en, i_mem_w_en, i_sram_ready,
               i_branch_taken,
`ifdef PIPE_CTRL_STATS_EN
        input  o_stall_cycles, o_flush_count, o_timeout_count,
`endif
        input  o_sram_req, o_sram_freeze, o_freeze, o_flush, o_id_bubble,
               o_sram_err
    );

endinterface

// File: rtl/pipe_ctrl_sram_access_fsm.sv
// sram_access_fsm -- sequences one SRAM access from the MEM stage.
//   clk, rst       : rising-edge clock, asynchronous active-high reset
//   i_mem_req      : MEM stage wants a read or write
//   i_sram_ready   : SRAM reports the access complete
//   o_sram_req     : access strobe, high in every ACCESS cycle
//   o_sram_freeze  : whole-pipeline hold (IDLE with request pending, ACCESS)
//   o_sram_err     : one-cycle pulse in DONE when the access timed out
// An access lasts at most SRAM_WAIT_MAX ACCESS cycles. DONE always lasts one
// cycle with freeze released, so the pipeline moves exactly one step.
module sram_access_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int SRAM_WAIT_MAX = SRAM_WAIT_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_mem_req,
    input  logic i_sram_ready,
    output logic o_sram_req,
    output logic o_sram_freeze,
    output logic o_sram_err
);

    // Counter holds 0 .. SRAM_WAIT_MAX-1 (ACCESS cycles already completed).
    localparam int              CNT_W    = (SRAM_WAIT_MAX < 2) ? 1 : $clog2(SRAM_WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT_MAX - 1);

    sram_state_e      r_state;
    sram_state_e      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_last;
    logic             w_enter;
    logic             w_to_err;

    // The current ACCESS cycle is the last one the budget allows.
    assign w_last = (r_cnt == CNT_LAST);

    // Next-state decode; ready in the final budget cycle counts as success.
    always_comb begin
        w_next   = r_state;
        w_enter  = 1'b0;
        w_to_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_mem_req) begin
                    w_next  = ACCESS;
                    w_enter = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            ACCESS: begin
                if (i_sram_ready) begin
                    w_next = DONE;
                end else if (w_last) begin
                    w_next   = DONE;
                    w_to_err = 1'b1;
                end else begin
                    w_next = ACCESS;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait counter: cleared on ACCESS entry, advanced per ACCESS cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_enter) begin
            r_cnt <= '0;
        end else if ((r_state == ACCESS) && !w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Remembers that the access just finished by timeout, for the DONE pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_err;
        end
    end

    assign o_sram_req    = (r_state == ACCESS);
    // Gated by rst so a pending request cannot leak out during reset.
    assign o_sram_freeze = ~rst & ((r_state == ACCESS) | ((r_state == IDLE) & i_mem_req));
    assign o_sram_err    = (r_state == DONE) & r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard detection, flush/freeze priority and SRAM access control.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : pipe_ctrl_if.slave carrying all pipeline and SRAM signals
// Priority is sram_freeze > flush > hazard freeze. A branch resolved while the
// SRAM holds the pipeline is flushed in the first unfrozen cycle, because EXE
// keeps presenting branch_taken until then.
// Optional macro PIPE_CTRL_STATS_EN adds saturating 32-bit statistics:
// stall cycles, flush cycles and SRAM timeouts.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int SRAM_WAIT_MAX = SRAM_WAIT_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    logic w_mem_req;
    logic w_sram_req;
    logic w_sram_freeze;
    logic w_sram_err;
    logic w_hit1_exe;
    logic w_hit2_exe;
    logic w_hit1_mem;
    logic w_hit2_mem;
    logic w_hazard;
    logic w_flush;
    logic w_freeze;

    assign w_mem_req = bus.i_mem_r_en | bus.i_mem_w_en;

    sram_access_fsm #(
        .SRAM_WAIT_MAX (SRAM_WAIT_MAX)
    ) u_sram_fsm (
        .clk           (clk),
        .rst           (rst),
        .i_mem_req     (w_mem_req),
        .i_sram_ready  (bus.i_sram_ready),
        .o_sram_req    (w_sram_req),
        .o_sram_freeze (w_sram_freeze),
        .o_sram_err    (w_sram_err)
    );

    assign w_hit1_exe = reg_hit(bus.i_id_src1, bus.i_exe_dest, bus.i_exe_wb_en);
    assign w_hit2_exe = reg_hit(bus.i_id_src2, bus.i_exe_dest, bus.i_exe_wb_en) & bus.i_id_two_src;
    assign w_hit1_mem = reg_hit(bus.i_id_src1, bus.i_mem_dest, bus.i_mem_wb_en);
    assign w_hit2_mem = reg_hit(bus.i_id_src2, bus.i_mem_dest, bus.i_mem_wb_en) & bus.i_id_two_src;

    // With forwarding only a load in EXE cannot be bypassed in time.
    always_comb begin
        w_hazard = 1'b0;
        if (bus.i_fwd_en) begin
            w_hazard = bus.i_exe_mem_r_en & (w_hit1_exe | w_hit2_exe);
        end else begin
            w_hazard = w_hit1_exe | w_hit2_exe | w_hit1_mem | w_hit2_mem;
        end
    end

    assign w_flush  = ~rst & bus.i_branch_taken & ~w_sram_freeze;
    assign w_freeze = ~rst & w_hazard & ~w_flush & ~w_sram_freeze;

    assign bus.o_sram_req    = w_sram_req;
    assign bus.o_sram_freeze = w_sram_freeze;
    assign bus.o_sram_err    = w_sram_err;
    assign bus.o_flush       = w_flush;
    assign bus.o_freeze      = w_freeze;
    assign bus.o_id_bubble   = w_freeze;

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic [31:0] r_timeout_count;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles  <= 32'd0;
            r_flush_count   <= 32'd0;
            r_timeout_count <= 32'd0;
        end else begin
            r_stall_cycles  <= sat_inc(r_stall_cycles, w_freeze | w_sram_freeze);
            r_flush_count   <= sat_inc(r_flush_count, w_flush);
            r_timeout_count <= sat_inc(r_timeout_count, w_sram_err);
        end
    end

    assign bus.o_stall_cycles  = r_stall_cycles;
    assign bus.o_flush_count   = r_flush_count;
    assign bus.o_timeout_count = r_timeout_count;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- scoreboard bench for pipe_ctrl (default SRAM_WAIT_MAX = 15).
// The stimulus process drives one input vector per cycle, asks a behavioural
// model what every output must be during that cycle and queues the answer;
// the monitor compares on the falling edge.
module tb_pipe_ctrl;

    localparam int WAIT_MAX = 15;

    typedef struct packed {
        logic       rst;
        logic       fwd;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic [3:0] ed;
        logic [3:0] md;
        logic       ewb;
        logic       mwb;
        logic       ld;
        logic       mr;
        logic       mw;
        logic       rdy;
        logic       bt;
    } stim_t;

    typedef struct packed {
        logic        req;
        logic        sfrz;
        logic        frz;
        logic        fl;
        logic        bub;
        logic        err;
        logic [31:0] st;
        logic [31:0] fc;
        logic [31:0] tc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Model of the SRAM handshake: busy while an access is outstanding,
    // settle for the single release cycle that follows it.
    bit          m_busy       = 1'b0;
    int          m_elapsed    = 0;
    bit          m_settle     = 1'b0;
    bit          m_settle_err = 1'b0;
    logic [31:0] m_st = 32'd0;
    logic [31:0] m_fc = 32'd0;
    logic [31:0] m_tc = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] sat1(input logic [31:0] v, input logic en);
        if (en && v != 32'hFFFF_FFFF) return v + 32'd1;
        return v;
    endfunction

    // Apply one input vector for one cycle and queue the expected outputs.
    task automatic cyc(input stim_t s);
        exp_t e;
        bit   hz;
        @(posedge clk);
        #1;
        rst                = s.rst;
        bus.i_fwd_en       = s.fwd;
        bus.i_id_src1      = s.s1;
        bus.i_id_src2      = s.s2;
        bus.i_id_two_src   = s.two;
        bus.i_exe_dest     = s.ed;
        bus.i_mem_dest     = s.md;
        bus.i_exe_wb_en    = s.ewb;
        bus.i_mem_wb_en    = s.mwb;
        bus.i_exe_mem_r_en = s.ld;
        bus.i_mem_r_en     = s.mr;
        bus.i_mem_w_en     = s.mw;
        bus.i_sram_ready   = s.rdy;
        bus.i_branch_taken = s.bt;
        e = '0;
        if (s.rst) begin
            m_busy = 1'b0; m_elapsed = 0; m_settle = 1'b0; m_settle_err = 1'b0;
            m_st = 32'd0; m_fc = 32'd0; m_tc = 32'd0;
            exp_q.push_back(e);
        end else begin
            if (s.fwd)
                hz = s.ld && s.ewb && (s.s1 == s.ed || (s.two && s.s2 == s.ed));
            else
                hz = (s.ewb && s.s1 == s.ed) || (s.mwb && s.s1 == s.md) ||
                     (s.two && ((s.ewb && s.s2 == s.ed) || (s.mwb && s.s2 == s.md)));
            e.req  = m_busy;
            e.sfrz = m_busy || (!m_settle && (s.mr || s.mw));
            e.err  = m_settle && m_settle_err;
            e.fl   = s.bt && !e.sfrz;
            e.frz  = hz && !e.fl && !e.sfrz;
            e.bub  = e.frz;
            e.st   = m_st;
            e.fc   = m_fc;
            e.tc   = m_tc;
            exp_q.push_back(e);
            m_st = sat1(m_st, e.frz | e.sfrz);
            m_fc = sat1(m_fc, e.fl);
            m_tc = sat1(m_tc, e.err);
            if (m_settle) begin
                m_settle = 1'b0;
            end else if (m_busy) begin
                m_elapsed++;
                if (s.rdy) begin
                    m_busy = 1'b0; m_settle = 1'b1; m_settle_err = 1'b0;
                end else if (m_elapsed == WAIT_MAX) begin
                    m_busy = 1'b0; m_settle = 1'b1; m_settle_err = 1'b1;
                end
            end else if (s.mr || s.mw) begin
                m_busy = 1'b1; m_elapsed = 0;
            end
        end
    endtask

    // Monitor: compare whatever the DUT shows mid-cycle against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sram_req",    {31'd0, bus.o_sram_req},    {31'd0, e.req});
                chk("sram_freeze", {31'd0, bus.o_sram_freeze}, {31'd0, e.sfrz});
                chk("freeze",      {31'd0, bus.o_freeze},      {31'd0, e.frz});
                chk("flush",       {31'd0, bus.o_flush},       {31'd0, e.fl});
                chk("id_bubble",   {31'd0, bus.o_id_bubble},   {31'd0, e.bub});
                chk("sram_err",    {31'd0, bus.o_sram_err},    {31'd0, e.err});
`ifdef PIPE_CTRL_STATS_EN
                chk("stall_cycles",  bus.o_stall_cycles,  e.st);
                chk("flush_count",   bus.o_flush_count,   e.fc);
                chk("timeout_count", bus.o_timeout_count, e.tc);
`endif
            end
        end
    end

    // Stimulus: directed scenarios, then a randomized run.
    initial begin
        stim_t s;
        bus.i_fwd_en = 1'b0; bus.i_id_src1 = 4'd0; bus.i_id_src2 = 4'd0;
        bus.i_id_two_src = 1'b0; bus.i_exe_dest = 4'd0; bus.i_mem_dest = 4'd0;
        bus.i_exe_wb_en = 1'b0; bus.i_mem_wb_en = 1'b0; bus.i_exe_mem_r_en = 1'b0;
        bus.i_mem_r_en = 1'b0; bus.i_mem_w_en = 1'b0; bus.i_sram_ready = 1'b0;
        bus.i_branch_taken = 1'b0;

        // Reset with every interesting input active: all outputs must be 0.
        s = '0; s.rst = 1'b1; s.mr = 1'b1; s.bt = 1'b1; s.s1 = 4'd3; s.ed = 4'd3; s.ewb = 1'b1;
        cyc(s); cyc(s);
        s = '0; cyc(s);

        // Plain RAW hazard without forwarding.
        s = '0; s.s1 = 4'd3; s.ed = 4'd3; s.ewb = 1'b1; cyc(s);
        // Forwarding: ALU result forwards, a load does not.
        s = '0; s.fwd = 1'b1; s.s2 = 4'd5; s.two = 1'b1; s.ed = 4'd5; s.ewb = 1'b1; cyc(s);
        s.ld = 1'b1; cyc(s);
        // MEM-stage producer: hazard only without forwarding.
        s = '0; s.s1 = 4'd7; s.md = 4'd7; s.mwb = 1'b1; cyc(s);
        s.fwd = 1'b1; cyc(s);
        // src2 match ignored when the instruction has one source.
        s = '0; s.s2 = 4'd9; s.ed = 4'd9; s.ewb = 1'b1; cyc(s);
        s.two = 1'b1; cyc(s);

        // Read access, ready on the 4th ACCESS cycle, with a branch and a hazard pending.
        s = '0; s.mr = 1'b1; cyc(s);
        for (int i = 1; i <= 4; i++) begin
            s = '0; s.mr = 1'b1; s.bt = 1'b1; s.s1 = 4'd3; s.ed = 4'd3; s.ewb = 1'b1;
            s.rdy = (i == 4); cyc(s);
        end
        s = '0; s.mr = 1'b1; s.bt = 1'b1; s.s1 = 4'd3; s.ed = 4'd3; s.ewb = 1'b1; cyc(s);
        s = '0; cyc(s);

        // Write access that never completes: timeout after WAIT_MAX cycles.
        s = '0; s.mw = 1'b1; cyc(s);
        for (int i = 0; i < WAIT_MAX; i++) cyc(s);
        cyc(s);
        s = '0; cyc(s);

        // Ready arriving in the very last budget cycle counts as success.
        s = '0; s.mr = 1'b1; cyc(s);
        for (int i = 1; i <= WAIT_MAX; i++) begin
            s.rdy = (i == WAIT_MAX); cyc(s);
        end
        s = '0; cyc(s); cyc(s);

        // Reset during ACCESS abandons the access silently.
        s = '0; s.mr = 1'b1; cyc(s); cyc(s); cyc(s);
        s.rst = 1'b1; cyc(s); cyc(s);
        s = '0; cyc(s); cyc(s);

        // Randomized traffic on a small register space for frequent matches.
        for (int n = 0; n < 3000; n++) begin
            s.rst = ($urandom_range(0, 199) == 0);
            s.fwd = 1'($urandom_range(0, 1));
            s.s1  = 4'($urandom_range(0, 3));
            s.s2  = 4'($urandom_range(0, 3));
            s.two = 1'($urandom_range(0, 1));
            s.ed  = 4'($urandom_range(0, 3));
            s.md  = 4'($urandom_range(0, 3));
            s.ewb = 1'($urandom_range(0, 1));
            s.mwb = 1'($urandom_range(0, 1));
            s.ld  = 1'($urandom_range(0, 1));
            s.mr  = ($urandom_range(0, 7) == 0);
            s.mw  = ($urandom_range(0, 7) == 0);
            s.rdy = ($urandom_range(0, 3) == 0);
            s.bt  = ($urandom_range(0, 5) == 0);
            cyc(s);
        end

        s = '0; cyc(s);
        @(posedge clk); @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter SRAM_WAIT_MAX, default 15: maximum cycles spent in ACCESS before a forced timeout.
REQ-002 Reset is rst, asynchronous, active-high; clock is clk.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 fwd_en  in  1  forwarding unit active; only load-use hazards stall.
REQ-006 id_src1, id_src2  in  4 each  ID-stage source register numbers.
REQ-007 id_two_src  in  1  ID instruction reads id_src2.
REQ-008 exe_dest, mem_dest  in  4 each  destination registers in EXE and MEM.
REQ-009 exe_wb_en, mem_wb_en  in  1 each  EXE / MEM instruction writes back.
REQ-010 exe_mem_r_en  in  1  EXE instruction is a load.
REQ-011 mem_r_en, mem_w_en  in  1 each  MEM stage requests SRAM read / write.
REQ-012 sram_ready  in  1  SRAM access complete.
REQ-013 branch_taken  in  1  EXE resolved a taken branch.
REQ-014 sram_req  out  1  SRAM access strobe.
REQ-015 sram_freeze  out  1  freezes all pipeline registers.
REQ-016 freeze  out  1  holds PC and the IF/ID register.
REQ-017 flush  out  1  clears the IF/ID and ID/EXE instructions.
REQ-018 id_bubble  out  1  inserts a NOP into ID/EXE.
REQ-019 sram_err  out  1  one-cycle pulse on SRAM timeout.

Function
REQ-020 Hazard, fwd_en=0: src1 matches exe_dest with exe_wb_en, or src1 matches mem_dest with mem_wb_en; src2 is tested the same way only when id_two_src=1.
REQ-021 Hazard, fwd_en=1: only a src1/src2 match on exe_dest with exe_wb_en=1 and exe_mem_r_en=1.
REQ-022 FSM states IDLE, ACCESS, DONE: IDLE->ACCESS when mem_r_en|mem_w_en; ACCESS->DONE on sram_ready or timeout; DONE->IDLE unconditionally.
REQ-023 sram_freeze is combinational: asserted in IDLE with a request pending, and in ACCESS; deasserted in DONE so the pipeline advances exactly one cycle.
REQ-024 sram_req is asserted only in ACCESS, Moore-decoded.
REQ-025 The wait counter clears on ACCESS entry and increments each ACCESS cycle; when it reaches SRAM_WAIT_MAX without sram_ready -> DONE, with sram_err pulsed in DONE.
REQ-026 sram_ready and timeout in the same cycle: treated as success, no sram_err.
REQ-027 Priority: sram_freeze > flush > hazard; flush = branch_taken & ~sram_freeze.
REQ-028 freeze = hazard & ~flush & ~sram_freeze; id_bubble = freeze.
REQ-029 branch_taken while sram_freeze is high: flush is delayed to the first unfrozen cycle, since the EXE stage holds the branch.
REQ-030 Hazard, flush and freeze logic is combinational (zero latency); only the FSM, the counter and the statistics are registered.

Reset
REQ-031 While rst is high: state=IDLE, counter=0, and every output is 0 regardless of inputs.
REQ-032 Reset mid-ACCESS: the access is abandoned, sram_req drops asynchronously, and no sram_err is produced.

Configuration
REQ-033 Macro PIPE_CTRL_STATS_EN, when defined, adds three 32-bit outputs: stall_cycles (freeze|sram_freeze cycles), flush_count (flush cycles) and timeout_count (sram_err pulses); all saturate at 0xFFFFFFFF and reset to 0.
REQ-034 Without PIPE_CTRL_STATS_EN these ports and counters do not exist, and all other behaviour is identical.

Structure
REQ-035 Package pipe_ctrl_pkg holds the state typedef (IDLE/ACCESS/DONE), REG_W=4 and the default SRAM_WAIT_MAX.
REQ-036 The SRAM FSM and wait counter form sub-module sram_access_fsm; hazard and priority logic stay in pipe_ctrl.

Verification
REQ-037 fwd_en=0, id_src1=3, exe_dest=3, exe_wb_en=1 -> freeze=1, id_bubble=1, flush=0 in the same cycle.
REQ-038 fwd_en=1, id_src2=5, id_two_src=1, exe_dest=5, exe_wb_en=1, exe_mem_r_en=0 -> freeze=0; then set exe_mem_r_en=1 -> freeze=1.
REQ-039 mem_r_en=1, sram_ready rising after 4 ACCESS cycles -> sram_freeze high for 5 cycles, sram_req high for 4, DONE for 1 cycle, then IDLE.
REQ-040 SRAM_WAIT_MAX=3, sram_ready held 0 -> after 3 ACCESS cycles, DONE with sram_err=1 for exactly 1 cycle.
REQ-041 branch_taken=1 during ACCESS -> flush=0 until the DONE cycle, then flush=1; a simultaneous hazard yields freeze=0.
REQ-042 rst asserted during ACCESS -> sram_req, sram_freeze and sram_err are 0 immediately; with PIPE_CTRL_STATS_EN, all counters read 0.
